// File: rtl/uart_tx_fifo_serializer.sv
// uart_tx_fifo_serializer: FIFO-buffered UART transmitter; define UART_TX_PARITY_EN to add a parity bit per frame
module uart_tx_fifo_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          TX_clock_enable,
  input  logic                          Write_en,
  input  logic [DATA_WIDTH-1:0]         TX_data,
  output logic                          Full,
  output logic                          Empty,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Fill_level,
  output logic                          UART_TX_O
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (DATA_WIDTH < 5 || DATA_WIDTH > 8 || STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo_serializer: illegal parameter set");
  end
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic [2:0] cnt_q, cnt_d;
  logic tx_q, tx_d, full_q, ovf_q, push, pop;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign push = Write_en && !full_q;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign Full = full_q;
  assign Overflow = ovf_q;
  assign Fill_level = count_q;
  assign UART_TX_O = tx_q;
  assign Empty = (count_q == '0) && (state_q == S_IDLE);
  // FIFO storage: no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= TX_data;
  end
  // FIFO pointers, occupancy and flags; a write while full is dropped even if a pop frees space
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q <= count_d == (AW+1)'(FIFO_DEPTH);
      ovf_q <= Write_en && full_q;
    end
  end
  // Serializer state register; the line is registered so it idles high straight out of reset
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  // Next state and line value, advancing only on baud ticks; the last stop tick may load the next word directly
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    tx_d = tx_q;
    pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    if (TX_clock_enable) begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          pop = count_q != '0;
          state_d = pop ? S_START : S_IDLE;
        end
        S_START: begin
          tx_d = 1'b0;
          state_d = S_DATA;
        end
        S_DATA: begin
          tx_d = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(DATA_WIDTH - 1)) begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx_d = par_q;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          tx_d = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(STOP_BITS - 1)) begin
            cnt_d = '0;
            pop = count_q != '0;
            state_d = pop ? S_START : S_IDLE;
          end
        end
        default: begin
          tx_d = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      cnt_d = '0;
`ifdef UART_TX_PARITY_EN
      par_d = (^mem_q[rd_ptr_q]) ^ 1'(PARITY_ODD);
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// tb_uart_tx_fifo_serializer: directed vectors and frame sequences for the UART transmitter
module tb_uart_tx_fifo_serializer;
  logic clk = 1'b0, rstn = 1'b0, te = 1'b0, we = 1'b0, we2 = 1'b0;
  logic [7:0] d = '0;
  logic [6:0] d2 = '0;
  logic full, empty, ovf, tx, full2, empty2, ovf2, tx2;
  logic [2:0] fill;
  logic [1:0] fill2;
  int checks = 0, errors = 0;
  typedef struct {
    logic r, t, w;
    logic [7:0] d;
    logic tx, em, fu, ov;
    logic [2:0] fi;
  } vec_t;
  vec_t tbl [9];
  always #5 clk = ~clk;
  uart_tx_fifo_serializer dut (
    .Clock(clk), .Resetn(rstn), .TX_clock_enable(te), .Write_en(we), .TX_data(d),
    .Full(full), .Empty(empty), .Overflow(ovf), .Fill_level(fill), .UART_TX_O(tx)
  );
  uart_tx_fifo_serializer #(.DATA_WIDTH(7), .STOP_BITS(2), .FIFO_DEPTH(2), .PARITY_ODD(0)) dut2 (
    .Clock(clk), .Resetn(rstn), .TX_clock_enable(te), .Write_en(we2), .TX_data(d2),
    .Full(full2), .Empty(empty2), .Overflow(ovf2), .Fill_level(fill2), .UART_TX_O(tx2)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic t, input logic w, input logic [7:0] dd);
    rstn = r;
    te = t;
    we = w;
    d = dd;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    te = 1'b0;
    we = 1'b0;
  endtask
  task automatic frame(input logic [7:0] b, input int gap, input string tag);
    for (int i = 0; i < 10; i++) begin
      logic e;
      e = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      chk($sformatf("%s bit%0d", tag, i), 8'(tx), 8'(e));
      for (int k = 1; k < gap; k++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
      if (gap > 1) chk($sformatf("%s hold%0d", tag, i), 8'(tx), 8'(e));
    end
  endtask
  initial begin
    logic exp2 [11];
    int n2;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'hA6, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].w, tbl[i].d);
      chk($sformatf("vec%0d {tx,empty,full,ovf,fill}", i), {1'b0, tx, empty, full, ovf, fill},
          {1'b0, tbl[i].tx, tbl[i].em, tbl[i].fu, tbl[i].ov, tbl[i].fi});
    end
    frame(8'hA1, 1, "q0");
    chk("q0 fill", 8'(fill), 8'd2);
    frame(8'hA2, 1, "q1");
    chk("q1 fill", 8'(fill), 8'd1);
    frame(8'hA3, 1, "q2");
    chk("q2 fill", 8'(fill), 8'd0);
    chk("q2 empty", 8'(empty), 8'd0);
    frame(8'hA4, 1, "q3");
    chk("q3 empty", 8'(empty), 8'd1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      chk($sformatf("dropped word not sent %0d", i), 8'(tx), 8'd1);
    end
    cyc(1'b1, 1'b0, 1'b1, 8'hA5);
    chk("t1 write {empty,fill}", {3'b0, empty, fill}, {3'b0, 1'b0, 3'd1});
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t1 pop {tx,empty,fill}", {3'b0, tx, empty, fill}, {3'b0, 1'b1, 1'b0, 3'd0});
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    frame(8'hA5, 4, "t1");
    chk("t1 empty", 8'(empty), 8'd1);
    cyc(1'b1, 1'b0, 1'b1, 8'h01);
    cyc(1'b1, 1'b0, 1'b1, 8'h02);
    chk("t2 fill2", 8'(fill), 8'd2);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t2 fill1", 8'(fill), 8'd1);
    frame(8'h01, 2, "t2a");
    chk("t2 fill0", 8'(fill), 8'd0);
    chk("t2 busy", 8'(empty), 8'd0);
    frame(8'h02, 2, "t2b");
    chk("t2 empty", 8'(empty), 8'd1);
    cyc(1'b1, 1'b0, 1'b1, 8'h55);
    cyc(1'b1, 1'b0, 1'b1, 8'h66);
    cyc(1'b1, 1'b0, 1'b1, 8'h77);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t5 fill", 8'(fill), 8'd2);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t5 bit3 line", 8'(tx), 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t5 reset {tx,empty,full,fill}", {4'b0, tx, empty, full, fill[0]}, {4'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("t5 reset fill", 8'(fill), 8'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      chk($sformatf("t5 quiet %0d", i), {6'b0, tx, empty}, 8'b11);
    end
    exp2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef UART_TX_PARITY_EN
    n2 = 11;
`else
    n2 = 10;
`endif
    we2 = 1'b1;
    d2 = 7'h07;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    we2 = 1'b0;
    chk("t4 write {empty,fill}", {5'b0, empty2, fill2}, {5'b0, 1'b0, 2'd1});
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t4 pop line", 8'(tx2), 8'd1);
    for (int i = 0; i < n2; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      chk($sformatf("t4 bit%0d", i), 8'(tx2), 8'(exp2[(n2 == 10 && i >= 8) ? i + 1 : i]));
      if (i == n2 - 2) chk("t4 second stop pending", 8'(empty2), 8'd0);
    end
    chk("t4 empty", 8'(empty2), 8'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
